// File: rtl/rom_sequencer.sv
// rom_sequencer: fetch/execute controller for a 4-word, 2-bit instruction ROM (INC/JNO/HLT).
// Optional macro INSTR_COUNT_EN adds an 8-bit saturating retired-instruction counter on icount.
module rom_sequencer #(
  parameter int ACC_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 rom_sel1,
  output logic                 rom_sel2,
  input  logic [1:0]           rom_data,
  output logic [1:0]           pc,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 ovf,
  output logic                 busy,
  output logic                 halted,
  output logic                 err
`ifdef INSTR_COUNT_EN
  ,
  output logic [7:0]           icount
`endif
);

  typedef enum logic [2:0] {
    st_idle    = 3'd0,
    st_fetch   = 3'd1,
    st_exec    = 3'd2,
    st_operand = 3'd3,
    st_halt    = 3'd4
  } state_t;

  localparam logic [1:0] op_inc = 2'b00;
  localparam logic [1:0] op_jno = 2'b01;
  localparam logic [1:0] op_hlt = 2'b10;

  state_t     state_r;
  logic [1:0] ir_r;

  assign rom_sel1 = pc[1];
  assign rom_sel2 = pc[0];

  // Main sequencer: state, program counter, instruction register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= st_idle;
      ir_r    <= 2'b00;
      pc      <= 2'b00;
      acc     <= {ACC_WIDTH{1'b0}};
      ovf     <= 1'b0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state_r)
        st_idle: begin
          if (start) begin
            pc      <= 2'b00;
            acc     <= {ACC_WIDTH{1'b0}};
            ovf     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state_r <= st_fetch;
          end else begin
            state_r <= st_idle;
          end
        end
        st_fetch: begin
          ir_r    <= rom_data;
          pc      <= pc + 2'd1;
          state_r <= st_exec;
        end
        st_exec: begin
          case (ir_r)
            op_inc: begin
              {ovf, acc} <= {1'b0, acc} + {{ACC_WIDTH{1'b0}}, 1'b1};
              state_r    <= st_fetch;
            end
            op_jno: begin
              state_r <= st_operand;
            end
            op_hlt: begin
              busy    <= 1'b0;
              halted  <= 1'b1;
              state_r <= st_halt;
            end
            default: begin
              err     <= 1'b1;
              busy    <= 1'b0;
              halted  <= 1'b1;
              state_r <= st_halt;
            end
          endcase
        end
        st_operand: begin
          // Jump is taken only while the last INC did not carry out
          if (!ovf) begin
            pc <= rom_data;
          end else begin
            pc <= pc + 2'd1;
          end
          state_r <= st_fetch;
        end
        st_halt: begin
          state_r <= st_halt;
        end
        default: begin
          busy    <= 1'b0;
          halted  <= 1'b0;
          state_r <= st_idle;
        end
      endcase
    end
  end

`ifdef INSTR_COUNT_EN
  logic retire_s;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Retirement strobe: INC/HLT in EXEC, JNO in its OPERAND cycle; illegal opcodes never retire
  always_comb begin
    retire_s = 1'b0;
    if (state_r == st_exec) begin
      retire_s = (ir_r == op_inc) || (ir_r == op_hlt);
    end else if (state_r == st_operand) begin
      retire_s = 1'b1;
    end else begin
      retire_s = 1'b0;
    end
  end

  // Saturating retired-instruction counter, cleared when a new run starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icount <= 8'h00;
    end else if ((state_r == st_idle) && start) begin
      icount <= 8'h00;
    end else if (retire_s) begin
      icount <= sat_inc8(icount);
    end else begin
      icount <= icount;
    end
  end
`endif

endmodule
